// File: rtl/regwrite_arbiter.sv
// Two-requester round-robin arbiter for the register-file write port.
// Registers the winning write and counts cycles where both requesters contend.
module regwrite_arbiter #(
  parameter int DWIDTH    = 32,
  parameter int RSELWIDTH = 5,
  parameter int CWIDTH    = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 hold,
  input  logic                 valid0,
  input  logic                 valid1,
  input  logic [RSELWIDTH-1:0] addr0,
  input  logic [RSELWIDTH-1:0] addr1,
  input  logic [DWIDTH-1:0]    data0,
  input  logic [DWIDTH-1:0]    data1,
  output logic                 ready0,
  output logic                 ready1,
  output logic                 write_en,
  output logic [RSELWIDTH-1:0] write_address,
  output logic [DWIDTH-1:0]    write_data,
  output logic [CWIDTH-1:0]    conflict_count
);

  localparam logic [CWIDTH-1:0] CMAX = '1;

  logic                 prio;
  logic                 grant0;
  logic                 grant1;
  logic                 xfer;
  logic                 both;
  logic [RSELWIDTH-1:0] sel_addr;
  logic [DWIDTH-1:0]    sel_data;

  always_comb begin
    grant0 = valid0 && (!valid1 || !prio);
    grant1 = valid1 && (!valid0 || prio);
  end

  // rst gates ready so a transfer racing reset never handshakes
  assign ready0   = !rst && !hold && valid0 && grant0;
  assign ready1   = !rst && !hold && valid1 && grant1;
  assign xfer     = ready0 || ready1;
  assign both     = valid0 && valid1 && !hold;
  assign sel_addr = ready1 ? addr1 : addr0;
  assign sel_data = ready1 ? data1 : data0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      write_en       <= 1'b0;
      write_address  <= '0;
      write_data     <= '0;
      conflict_count <= '0;
      prio           <= 1'b0;
    end else begin
      write_en <= xfer && (sel_addr != '0);
      if (xfer) begin
        write_address <= sel_addr;
        write_data    <= sel_data;
        prio          <= ready0;
      end
      if (both && conflict_count != CMAX)
        conflict_count <= conflict_count + CWIDTH'(1);
    end
  end

endmodule

// File: tb/tb_regwrite_arbiter.sv
// Randomized scoreboard bench for regwrite_arbiter.
// A second instance with CWIDTH=2 exercises counter saturation.
module tb_regwrite_arbiter;

  localparam int DW = 32;
  localparam int RW = 5;
  localparam int CW = 16;

  typedef struct packed {
    logic [RW-1:0] a;
    logic [DW-1:0] d;
  } wr_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          hold = 1'b0;
  logic          valid0 = 1'b0;
  logic          valid1 = 1'b0;
  logic [RW-1:0] addr0 = '0;
  logic [RW-1:0] addr1 = '0;
  logic [DW-1:0] data0 = '0;
  logic [DW-1:0] data1 = '0;
  logic          ready0, ready1, write_en;
  logic [RW-1:0] write_address;
  logic [DW-1:0] write_data;
  logic [CW-1:0] conflict_count;
  logic          s_ready0, s_ready1, s_we;
  logic [RW-1:0] s_wa;
  logic [DW-1:0] s_wd;
  logic [1:0]    s_cc;

  always #5 clk = ~clk;

  regwrite_arbiter #(.DWIDTH(DW), .RSELWIDTH(RW), .CWIDTH(CW)) dut (
    .clk(clk), .rst(rst), .hold(hold),
    .valid0(valid0), .valid1(valid1),
    .addr0(addr0), .addr1(addr1),
    .data0(data0), .data1(data1),
    .ready0(ready0), .ready1(ready1),
    .write_en(write_en), .write_address(write_address),
    .write_data(write_data), .conflict_count(conflict_count)
  );

  regwrite_arbiter #(.DWIDTH(DW), .RSELWIDTH(RW), .CWIDTH(2)) dut_sat (
    .clk(clk), .rst(rst), .hold(hold),
    .valid0(valid0), .valid1(valid1),
    .addr0(addr0), .addr1(addr1),
    .data0(data0), .data1(data1),
    .ready0(s_ready0), .ready1(s_ready1),
    .write_en(s_we), .write_address(s_wa),
    .write_data(s_wd), .conflict_count(s_cc)
  );

  int checks = 0;
  int errors = 0;

  // reference state: who wins a tie, counts, last accepted write
  int            m_prio = 0;
  int            m_cnt  = 0;
  int            m_cnt2 = 0;
  logic [RW-1:0] m_addr = '0;
  logic [DW-1:0] m_data = '0;
  wr_t           exp_q[$];
  bit            t0, t1;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic accept(logic [RW-1:0] a, logic [DW-1:0] d);
    wr_t w;
    w.a = a;
    w.d = d;
    if (a != 0) exp_q.push_back(w);
    m_addr = a;
    m_data = d;
  endtask

  task automatic step(
    input logic          v0,
    input logic [RW-1:0] a0,
    input logic [DW-1:0] d0,
    input logic          v1,
    input logic [RW-1:0] a1,
    input logic [DW-1:0] d1,
    input logic          h,
    input bit            do_rst
  );
    bit e0, e1;
    @(negedge clk);
    valid0 = v0; addr0 = a0; data0 = d0;
    valid1 = v1; addr1 = a1; data1 = d1;
    hold = h;
    #1;
    e0 = v0 && !h && (!v1 || m_prio == 0);
    e1 = v1 && !h && (!v0 || m_prio == 1);
    chk("ready0", ready0, e0);
    chk("ready1", ready1, e1);
    chk("sat_ready0", s_ready0, e0);
    chk("sat_ready1", s_ready1, e1);
    t0 = e0;
    t1 = e1;
    if (do_rst) begin
      rst = 1'b1;
      #1;
      chk("rst_ready0", ready0, 0);
      chk("rst_ready1", ready1, 0);
      chk("rst_we", write_en, 0);
      chk("rst_waddr", write_address, 0);
      chk("rst_wdata", write_data, 0);
      chk("rst_count", conflict_count, 0);
      m_prio = 0; m_cnt = 0; m_cnt2 = 0;
      m_addr = '0; m_data = '0;
      exp_q.delete();
      t0 = 0; t1 = 0;
      @(negedge clk);
      rst = 1'b0;
      valid0 = 1'b0; valid1 = 1'b0; hold = 1'b0;
    end else begin
      if (v0 && v1 && !h) begin
        if (m_cnt < 65535) m_cnt++;
        if (m_cnt2 < 3) m_cnt2++;
      end
      if (e0) begin accept(a0, d0); m_prio = 1; end
      if (e1) begin accept(a1, d1); m_prio = 0; end
    end
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // monitor: registered outputs against the scoreboard after each edge
  initial begin
    wr_t w;
    forever begin
      @(posedge clk);
      #1;
      if (write_en) begin
        if (exp_q.size() == 0) begin
          chk("spurious_we", write_en, 0);
        end else begin
          w = exp_q.pop_front();
          chk("we_addr", write_address, w.a);
          chk("we_data", write_data, w.d);
        end
      end else if (exp_q.size() != 0) begin
        chk("missing_we", write_en, 1);
        void'(exp_q.pop_front());
      end
      chk("cur_addr", write_address, m_addr);
      chk("cur_data", write_data, m_data);
      chk("conflict_count", conflict_count, m_cnt);
      chk("conflict_sat", s_cc, m_cnt2);
    end
  end

  initial begin
    logic          pv0, pv1;
    logic [RW-1:0] pa0, pa1;
    logic [DW-1:0] pd0, pd1;
    bit            h, r;

    #1;
    chk("init_we", write_en, 0);
    chk("init_waddr", write_address, 0);
    chk("init_wdata", write_data, 0);
    chk("init_count", conflict_count, 0);
    chk("init_ready0", ready0, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // single requester
    step(1, 5, 32'hDEADBEEF, 0, 0, 0, 0, 0);
    idle();
    idle();

    // conflict straight out of reset
    step(0, 0, 0, 0, 0, 0, 0, 1);
    step(1, 3, 32'h0000_0303, 1, 4, 32'h0000_0404, 0, 0);
    step(0, 0, 0, 1, 4, 32'h0000_0404, 0, 0);
    idle();

    // zero register
    step(0, 0, 0, 1, 0, 32'h0000_1234, 0, 0);
    idle();

    // hold during conflict keeps the winner
    repeat (3) step(1, 8, 32'hAAAA_0008, 1, 9, 32'hBBBB_0009, 1, 0);
    step(1, 8, 32'hAAAA_0008, 1, 9, 32'hBBBB_0009, 0, 0);
    step(0, 0, 0, 1, 9, 32'hBBBB_0009, 0, 0);
    idle();

    // saturation on the narrow counter, same address both sides
    step(0, 0, 0, 0, 0, 0, 0, 1);
    repeat (5) step(1, 6, 32'h1111_1111, 1, 6, 32'h2222_2222, 0, 0);
    idle();

    // reset in the cycle of a transfer to r7
    step(1, 7, 32'h7777_7777, 0, 0, 0, 0, 1);
    idle();
    step(1, 2, 32'hC0DE_0002, 1, 10, 32'hC0DE_000A, 0, 0);
    step(0, 0, 0, 1, 10, 32'hC0DE_000A, 0, 0);
    idle();

    // randomized traffic honouring the hold-until-transfer rule
    pv0 = 0; pv1 = 0;
    pa0 = 0; pa1 = 0;
    pd0 = 0; pd1 = 0;
    for (int i = 0; i < 3000; i++) begin
      if (!pv0 && $urandom_range(0, 9) < 6) begin
        pv0 = 1;
        pa0 = ($urandom_range(0, 3) == 0) ? RW'($urandom) : RW'($urandom_range(0, 7));
        pd0 = $urandom;
      end
      if (!pv1 && $urandom_range(0, 9) < 6) begin
        pv1 = 1;
        pa1 = ($urandom_range(0, 3) == 0) ? RW'($urandom) : RW'($urandom_range(0, 7));
        pd1 = $urandom;
      end
      h = ($urandom_range(0, 9) == 0);
      r = ($urandom_range(0, 199) == 0);
      step(pv0, pa0, pd0, pv1, pa1, pd1, h, r);
      if (r) begin
        pv0 = 0;
        pv1 = 0;
      end else begin
        if (t0) pv0 = 0;
        if (t1) pv1 = 0;
      end
    end
    idle();
    idle();
    chk("queue_drained", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
